rv32i_decode_stage: RTL and testbench

Registered instruction-decode stage of the RV32I decoder, sitting directly upstream of the ALU control block. It accepts one 32-bit instruction per transfer over a valid/ready handshake. It decodes the opcode into the 2-bit ALU operation class and the 4-bit `funct` that ALU control consumes, plus register indices, sign-extended immediate and control flags. All outputs are held in a single pipeline register with backpressure, flush and a saturating illegal-instruction counter.

---
 rtl/rv32i_decode_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_rv32i_decode_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: registered RV32I instruction-decode stage feeding ALU control.
// Takes one instruction per valid/ready transfer. It decodes the instruction into
// the ALU operation class, funct, register indices, a sign-extended immediate and
// control flags, and holds the result in a single pipeline register.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   flush                    drop held bundle and suppress capture this cycle
//   in_valid/in_ready/in_instr   upstream handshake and instruction word
//   out_valid/out_ready      downstream handshake for the decoded bundle
//   alu_op, funct            ALU class and {funct7[5], funct3} for ALU control
//   rs1, rs2, rd, imm        register indices and sign-extended immediate
//   reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal   flags
//   illegal_cnt              saturating count of accepted illegal instructions
module rv32i_decode_stage #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       alu_op,
    output logic [3:0]       funct,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      imm,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic             alu_src_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_R      = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;
    localparam logic [1:0] ALU_I      = 2'b11;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [1:0]  dec_alu_op;
    logic [3:0]  dec_funct;
    logic [31:0] dec_imm;
    logic        dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_branch, dec_jump, dec_alu_src_imm, dec_illegal;

    logic             out_valid_q, out_valid_d;
    logic [1:0]       alu_op_q;
    logic [3:0]       funct_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [31:0]      imm_q;
    logic             reg_write_q, mem_read_q, mem_write_q;
    logic             branch_q, jump_q, alu_src_imm_q, illegal_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Immediate formats, all sign-extended from instr[31]
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    // Opcode decode; unknown opcodes fall through to the illegal default
    always_comb begin
        dec_alu_op      = ALU_ADD;
        dec_funct       = 4'b0000;
        dec_imm         = 32'h0;
        dec_reg_write   = 1'b0;
        dec_mem_read    = 1'b0;
        dec_mem_write   = 1'b0;
        dec_branch      = 1'b0;
        dec_jump        = 1'b0;
        dec_alu_src_imm = 1'b0;
        dec_illegal     = 1'b0;
        case (opcode)
            OP_R: begin
                dec_alu_op    = ALU_R;
                dec_funct     = {in_instr[30], funct3};
                dec_reg_write = 1'b1;
            end
            OP_I_ALU: begin
                // instr[30] only distinguishes srai from srli; elsewhere it is immediate data
                dec_alu_op      = ALU_I;
                dec_funct       = {(funct3 == 3'b101) ? in_instr[30] : 1'b0, funct3};
                dec_imm         = imm_i;
                dec_alu_src_imm = 1'b1;
                dec_reg_write   = 1'b1;
            end
            OP_LOAD: begin
                dec_imm         = imm_i;
                dec_mem_read    = 1'b1;
                dec_reg_write   = 1'b1;
                dec_alu_src_imm = 1'b1;
            end
            OP_STORE: begin
                dec_imm         = imm_s;
                dec_mem_write   = 1'b1;
                dec_alu_src_imm = 1'b1;
            end
            OP_BRANCH: begin
                dec_alu_op = ALU_BRANCH;
                dec_funct  = {1'b0, funct3};
                dec_imm    = imm_b;
                dec_branch = 1'b1;
            end
            OP_JAL: begin
                dec_imm       = imm_j;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_JALR: begin
                dec_imm         = imm_i;
                dec_jump        = 1'b1;
                dec_reg_write   = 1'b1;
                dec_alu_src_imm = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm         = imm_u;
                dec_alu_src_imm = 1'b1;
                dec_reg_write   = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Output-valid and counter next state
    always_comb begin
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (capture && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register; bundle data only changes on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            alu_op_q      <= 2'b00;
            funct_q       <= 4'b0000;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            rd_q          <= 5'd0;
            imm_q         <= 32'h0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            branch_q      <= 1'b0;
            jump_q        <= 1'b0;
            alu_src_imm_q <= 1'b0;
            illegal_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            if (capture) begin
                alu_op_q      <= dec_alu_op;
                funct_q       <= dec_funct;
                rs1_q         <= in_instr[19:15];
                rs2_q         <= in_instr[24:20];
                rd_q          <= in_instr[11:7];
                imm_q         <= dec_imm;
                reg_write_q   <= dec_reg_write;
                mem_read_q    <= dec_mem_read;
                mem_write_q   <= dec_mem_write;
                branch_q      <= dec_branch;
                jump_q        <= dec_jump;
                alu_src_imm_q <= dec_alu_src_imm;
                illegal_q     <= dec_illegal;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_op      = alu_op_q;
    assign funct       = funct_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign imm         = imm_q;
    assign reg_write   = reg_write_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign branch      = branch_q;
    assign jump        = jump_q;
    assign alu_src_imm = alu_src_imm_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: vector table driven through a scoreboard queue,
// with a wide-counter and a 2-bit-counter instance sharing the same stimulus.
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr;

    logic        in_ready, out_valid;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal;
    logic [7:0]  illegal_cnt;

    logic        n_in_ready, n_out_valid;
    logic [1:0]  n_alu_op;
    logic [3:0]  n_funct;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    logic [31:0] n_imm;
    logic        n_reg_write, n_mem_read, n_mem_write, n_branch, n_jump, n_alu_src_imm, n_illegal;
    logic [1:0]  n_illegal_cnt;

    rv32i_decode_stage #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .funct(funct), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .alu_src_imm(alu_src_imm), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    rv32i_decode_stage #(.CNT_W(2)) u_dut_n (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .out_valid(n_out_valid), .out_ready(out_ready),
        .alu_op(n_alu_op), .funct(n_funct), .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd), .imm(n_imm),
        .reg_write(n_reg_write), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .branch(n_branch), .jump(n_jump), .alu_src_imm(n_alu_src_imm), .illegal(n_illegal),
        .illegal_cnt(n_illegal_cnt)
    );

    always #5 clk = ~clk;

    // flags = {reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal}
    typedef struct {
        logic [31:0] instr;
        logic [1:0]  alu_op;
        logic [3:0]  funct;
        logic [31:0] imm;
        logic [6:0]  flags;
    } vec_t;

    vec_t vecs[16];
    vec_t sbq[$];
    vec_t cur_exp;
    vec_t v_zero, v_sw, v_lui, v_addi, v_add, v_jal;
    bit   m_valid;
    int   m_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic [1:0] a, input logic [3:0] f,
                                input logic [31:0] im, input logic [6:0] fl);
        vec_t v;
        v.instr = i; v.alu_op = a; v.funct = f; v.imm = im; v.flags = fl;
        return v;
    endfunction

    function automatic logic [63:0] exp_bundle(input vec_t v);
        return 64'({v.alu_op, v.funct, v.instr[19:15], v.instr[24:20], v.instr[11:7], v.imm, v.flags});
    endfunction

    function automatic logic [63:0] act_bundle();
        return 64'({alu_op, funct, rs1, rs2, rd, imm,
                    reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal});
    endfunction

    function automatic logic [63:0] act_bundle_n();
        return 64'({n_alu_op, n_funct, n_rs1, n_rs2, n_rd, n_imm,
                    n_reg_write, n_mem_read, n_mem_write, n_branch, n_jump, n_alu_src_imm, n_illegal});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one instruction and hold it until accepted (bounded)
    task automatic send(input vec_t v);
        int k;
        k = 0;
        cur_exp  = v;
        in_instr = v.instr;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: instr %h never accepted", v.instr);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compares DUT state to the model at each falling edge,
    // then advances the model by what the next rising edge will do.
    initial begin
        m_valid = 1'b0;
        m_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                m_valid = 1'b0;
                m_cnt   = 0;
            end else begin
                check("out_valid", 64'(out_valid), 64'(m_valid));
                check("n_out_valid", 64'(n_out_valid), 64'(m_valid));
                check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
                check("illegal_cnt", 64'(illegal_cnt), 64'((m_cnt > 255) ? 255 : m_cnt));
                check("n_illegal_cnt", 64'(n_illegal_cnt), 64'((m_cnt > 3) ? 3 : m_cnt));
                if (m_valid) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard_empty: valid bundle with no expectation");
                    end else begin
                        check("bundle", act_bundle(), exp_bundle(sbq[0]));
                        check("n_bundle", act_bundle_n(), exp_bundle(sbq[0]));
                        if (out_ready || flush) void'(sbq.pop_front());
                    end
                end
                if (in_valid && (!m_valid || out_ready) && !flush) begin
                    sbq.push_back(cur_exp);
                    if (cur_exp.flags[0]) m_cnt++;
                    m_valid = 1'b1;
                end else if (flush || out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = 32'h0;

        vecs[0]  = mk(32'h002081B3, 2'b01, 4'b0000, 32'h00000000, 7'b1000000); // add x3,x1,x2
        vecs[1]  = mk(32'hFFF00093, 2'b11, 4'b0000, 32'hFFFFFFFF, 7'b1000010); // addi x1,x0,-1
        vecs[2]  = mk(32'h40335293, 2'b11, 4'b1101, 32'h00000403, 7'b1000010); // srai x5,x6,3
        vecs[3]  = mk(32'hFE208EE3, 2'b10, 4'b0000, 32'hFFFFFFFC, 7'b0001000); // beq -4
        vecs[4]  = mk(32'h0020A423, 2'b00, 4'b0000, 32'h00000008, 7'b0010010); // sw x2,8(x1)
        vecs[5]  = mk(32'h00000000, 2'b00, 4'b0000, 32'h00000000, 7'b0000001); // illegal
        vecs[6]  = mk(32'h123452B7, 2'b00, 4'b0000, 32'h12345000, 7'b1000010); // lui
        vecs[7]  = mk(32'hFFFFF517, 2'b00, 4'b0000, 32'hFFFFF000, 7'b1000010); // auipc
        vecs[8]  = mk(32'h008000EF, 2'b00, 4'b0000, 32'h00000008, 7'b1000100); // jal x1,8
        vecs[9]  = mk(32'h000080E7, 2'b00, 4'b0000, 32'h00000000, 7'b1000110); // jalr x1,0(x1)
        vecs[10] = mk(32'hFFC12183, 2'b00, 4'b0000, 32'hFFFFFFFC, 7'b1100010); // lw x3,-4(x2)
        vecs[11] = mk(32'h00000073, 2'b00, 4'b0000, 32'h00000000, 7'b0000001); // ecall: illegal
        vecs[12] = mk(32'h40208033, 2'b01, 4'b1000, 32'h00000000, 7'b1000000); // sub
        vecs[13] = mk(32'h40008093, 2'b11, 4'b0000, 32'h00000400, 7'b1000010); // addi, bit30 set
        vecs[14] = mk(32'hFE20DEE3, 2'b10, 4'b0101, 32'hFFFFFFFC, 7'b0001000); // bge -4
        vecs[15] = mk(32'hFE112E23, 2'b00, 4'b0000, 32'hFFFFFFFC, 7'b0010010); // sw x1,-4(x2)
        v_add = vecs[0]; v_addi = vecs[1]; v_sw = vecs[4]; v_zero = vecs[5];
        v_lui = vecs[6]; v_jal = vecs[8];

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_cnt", 64'(illegal_cnt), 64'(0));
        check("rst_bundle", act_bundle(), 64'(0));
        check("rst_n_bundle", act_bundle_n(), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_hold", 64'(in_ready), 64'(1));
        check("rst_out_valid_hold", 64'(out_valid), 64'(0));
        rst = 1'b0;

        // Three illegal instructions back to back
        for (int i = 0; i < 3; i++) send(v_zero);
        repeat (2) @(posedge clk);
        #1;
        check("cnt_after_3", 64'(illegal_cnt), 64'(3));
        check("n_cnt_after_3", 64'(n_illegal_cnt), 64'(3));

        // Full table at one instruction per cycle
        for (int i = 0; i < 16; i++) send(vecs[i]);
        repeat (2) @(posedge clk);
        #1;
        check("cnt_after_5", 64'(illegal_cnt), 64'(5));
        check("n_cnt_saturated", 64'(n_illegal_cnt), 64'(3));

        // Backpressure: sw held for 3 cycles, second instruction waits
        out_ready = 1'b0;
        send(v_sw);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            send(v_lui);
        join
        repeat (2) @(posedge clk);
        #1;

        // Flush with a held bundle and blocked input
        out_ready = 1'b0;
        send(v_addi);
        cur_exp = v_add; in_instr = v_add.instr; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_blocked_valid", 64'(out_valid), 64'(0));

        // Flush with an illegal instruction that would otherwise be accepted
        send(v_addi);
        out_ready = 1'b1;
        cur_exp = v_zero; in_instr = v_zero.instr; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_open_valid", 64'(out_valid), 64'(0));
        check("flush_cnt", 64'(illegal_cnt), 64'(5));
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a held bundle
        out_ready = 1'b0;
        send(v_jal);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_cnt", 64'(illegal_cnt), 64'(0));
        check("midrst_n_cnt", 64'(n_illegal_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(v_add);
        check("post_rst_valid", 64'(out_valid), 64'(1));
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
